// File: rtl/selfcomp_monitor.sv
// selfcomp_monitor: observes NUM_COPIES self-composed copies of a DUT that share
// one input handshake, and flags timing divergence between the copies.
//
// Per transaction it measures each copy's completion latency (cycles from the
// input accept to the copy's first output handshake), reports the set of copies
// that finished first, the spread between first and last completion, copy-0
// latency, a timeout if some copy never answers, and protocol misuse.
//
// Optional feature (macro SELFCOMP_RESULT_CHECK_EN): capture each copy's result
// at completion and compare all of them against copy 0 in the CHECK cycle.
//
// Handshake semantics: an input transfer happens on a rising edge where
// io_in_valid & io_in_ready are both 1; copy i's output transfer happens on a
// rising edge where io_out_valid[i] & io_out_ready are both 1. Only the first
// output transfer of each copy per transaction counts; later ones are ignored.
module selfcomp_monitor #(
  parameter int NUM_COPIES = 2,
  parameter int DATA_W     = 128,
  parameter int CNT_W      = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         io_in_valid,
  input  logic                         io_in_ready,
  input  logic [NUM_COPIES-1:0]        io_out_valid,
  input  logic                         io_out_ready,
  input  logic [NUM_COPIES*DATA_W-1:0] io_out_result,
  output logic                         busy,
  output logic                         allValid,
  output logic                         timingLeak,
  output logic                         timingLeakDone,
  output logic [NUM_COPIES-1:0]        leakMask,
  output logic [CNT_W-1:0]             skew,
  output logic [CNT_W-1:0]             lat0,
  output logic                         timeout,
  output logic [15:0]                  txnCount,
  output logic                         protoErr,
  output logic                         resultMismatch
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t                  state_q;
  state_t                  state_d;

  logic                    accept;
  logic                    in_busy;
  logic [NUM_COPIES-1:0]   done_q;
  logic [NUM_COPIES-1:0]   comp;
  logic                    all_done;
  logic                    diverge;
  logic                    tmo_hit;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        lat_now;
  logic [CNT_W-1:0]        first_lat_q;
  logic [CNT_W-1:0]        last_lat_q;
  logic [CNT_W-1:0]        lat0_q;

  assign accept  = io_in_valid & io_in_ready;
  assign in_busy = (state_q == ST_BUSY);

  // Per-cycle completion events: first output handshake of each copy while BUSY.
  always_comb begin
    comp = '0;
    if (in_busy) begin
      comp = io_out_valid & ~done_q & {NUM_COPIES{io_out_ready}};
    end
  end

  // Latency of a completion at this edge (counter + 1), held at the counter maximum.
  always_comb begin
    lat_now = cnt_q + 1'b1;
    if (cnt_q == CNT_MAX) begin
      lat_now = CNT_MAX;
    end
  end

  // Divergence, all-done and timeout decisions for the current BUSY cycle.
  // A completion in the timeout cycle wins: the timeout is deferred to a cycle
  // with no completion.
  always_comb begin
    all_done = &(done_q | comp);
    diverge  = in_busy && (comp != '0) && ((~comp & ~done_q) != '0);
    tmo_hit  = in_busy && !all_done && (comp == '0) && (lat_now >= TIMEOUT_C);
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (all_done || tmo_hit) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy           = (state_q != ST_IDLE);
  assign timingLeakDone = (state_q == ST_CHECK);

  // Registered AND of the per-copy output valids.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      allValid <= 1'b0;
    end else begin
      allValid <= &io_out_valid;
    end
  end

  // Cycle counter and per-copy done mask for the outstanding transaction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      done_q <= '0;
    end else if (state_q == ST_IDLE) begin
      if (accept) begin
        cnt_q  <= '0;
        done_q <= '0;
      end
    end else if (in_busy) begin
      if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
      done_q <= done_q | comp;
    end
  end

  // First/last completion latency, copy-0 latency and the first-finisher mask.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      leakMask    <= '0;
      first_lat_q <= '0;
      last_lat_q  <= '0;
      lat0_q      <= '0;
    end else if (state_q == ST_IDLE) begin
      if (accept) begin
        leakMask    <= '0;
        first_lat_q <= '0;
        last_lat_q  <= '0;
        lat0_q      <= '0;
      end
    end else if (in_busy && (comp != '0)) begin
      if (done_q == '0) begin
        leakMask    <= comp;
        first_lat_q <= lat_now;
      end
      last_lat_q <= lat_now;
      if (comp[0]) begin
        lat0_q <= lat_now;
      end
    end
  end

  // Sticky divergence and timeout flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timingLeak <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      if (diverge || tmo_hit) begin
        timingLeak <= 1'b1;
      end
      if (tmo_hit) begin
        timeout <= 1'b1;
      end
    end
  end

  // An accept while a transaction is still open is a protocol error; it is dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      protoErr <= 1'b0;
    end else if (accept && (state_q != ST_IDLE)) begin
      protoErr <= 1'b1;
    end
  end

  // End-of-transaction publication: counter, skew and copy-0 latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      txnCount <= '0;
      skew     <= '0;
      lat0     <= '0;
    end else if (state_q == ST_CHECK) begin
      txnCount <= txnCount + 16'd1;
      skew     <= last_lat_q - first_lat_q;
      lat0     <= lat0_q;
    end
  end

`ifdef SELFCOMP_RESULT_CHECK_EN
  logic [DATA_W-1:0] res_q [NUM_COPIES];
  logic              res_diff;

  // Capture each copy's result at its completion; clear at accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_COPIES; i++) begin
        res_q[i] <= '0;
      end
    end else if ((state_q == ST_IDLE) && accept) begin
      for (int i = 0; i < NUM_COPIES; i++) begin
        res_q[i] <= '0;
      end
    end else if (in_busy) begin
      for (int i = 0; i < NUM_COPIES; i++) begin
        if (comp[i]) begin
          res_q[i] <= io_out_result[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Compare every completed copy's result against copy 0.
  always_comb begin
    res_diff = 1'b0;
    for (int i = 1; i < NUM_COPIES; i++) begin
      if (done_q[i] && done_q[0] && (res_q[i] != res_q[0])) begin
        res_diff = 1'b1;
      end
    end
  end

  // Sticky result-divergence flag, evaluated in the CHECK cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resultMismatch <= 1'b0;
    end else if ((state_q == ST_CHECK) && res_diff) begin
      resultMismatch <= 1'b1;
    end
  end
`else
  logic unused_result;

  assign unused_result  = ^io_out_result;
  assign resultMismatch = 1'b0;
`endif

endmodule

// File: tb/tb_selfcomp_monitor.sv
// tb_selfcomp_monitor: directed table of two-copy transactions plus hand-written
// sequences for back-to-back transactions, reset mid-BUSY, allValid and the
// optional result comparison (SELFCOMP_RESULT_CHECK_EN).
module tb_selfcomp_monitor;

  localparam int NC = 2;
  localparam int DW = 128;
  localparam int CW = 8;

  logic             clock;
  logic             reset;
  logic             io_in_valid;
  logic             io_in_ready;
  logic [NC-1:0]    io_out_valid;
  logic             io_out_ready;
  logic [NC*DW-1:0] io_out_result;
  logic             busy;
  logic             allValid;
  logic             timingLeak;
  logic             timingLeakDone;
  logic [NC-1:0]    leakMask;
  logic [CW-1:0]    skew;
  logic [CW-1:0]    lat0;
  logic             timeout;
  logic [15:0]      txnCount;
  logic             protoErr;
  logic             resultMismatch;

  int total;
  int bad;

  selfcomp_monitor #(
    .NUM_COPIES(NC),
    .DATA_W    (DW),
    .CNT_W     (CW),
    .TIMEOUT   (255)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .io_in_valid    (io_in_valid),
    .io_in_ready    (io_in_ready),
    .io_out_valid   (io_out_valid),
    .io_out_ready   (io_out_ready),
    .io_out_result  (io_out_result),
    .busy           (busy),
    .allValid       (allValid),
    .timingLeak     (timingLeak),
    .timingLeakDone (timingLeakDone),
    .leakMask       (leakMask),
    .skew           (skew),
    .lat0           (lat0),
    .timeout        (timeout),
    .txnCount       (txnCount),
    .protoErr       (protoErr),
    .resultMismatch (resultMismatch)
  );

  // Clock and reset.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One comparison.
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Synchronous-looking reset pulse applied away from the rising edge.
  task automatic do_reset();
    reset         = 1'b1;
    io_in_valid   = 1'b0;
    io_in_ready   = 1'b0;
    io_out_valid  = '0;
    io_out_ready  = 1'b1;
    io_out_result = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Accept a transaction, then hold copy i valid from cycle lat_i onward
  // (0 = never). dup: cycle in which a second accept is driven (0 = none).
  // nr: cycle in which io_out_ready is low (0 = none).
  task automatic run_txn(input int la, input int lb, input int dup, input int nr,
                         input logic [DW-1:0] ra, input logic [DW-1:0] rb,
                         output int busy_cnt, output int done_cnt, output bit hung);
    io_in_valid   = 1'b1;
    io_in_ready   = 1'b1;
    io_out_result = {rb, ra};
    @(negedge clock);
    io_in_valid = 1'b0;
    io_in_ready = 1'b0;
    busy_cnt = busy ? 1 : 0;
    done_cnt = timingLeakDone ? 1 : 0;
    hung = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      io_out_valid[0] = (la != 0) && (k >= la);
      io_out_valid[1] = (lb != 0) && (k >= lb);
      io_out_ready    = (k != nr);
      io_in_valid     = (k == dup);
      io_in_ready     = (k == dup);
      @(negedge clock);
      if (busy) busy_cnt++;
      if (timingLeakDone) done_cnt++;
      if (!busy) begin
        hung = 1'b0;
        break;
      end
    end
    io_out_valid = '0;
    io_out_ready = 1'b1;
    io_in_valid  = 1'b0;
    io_in_ready  = 1'b0;
  endtask

  typedef struct {
    int la;
    int lb;
    int dup;
    int nr;
    bit exp_leak;
    int exp_mask;
    int exp_skew;
    int exp_lat0;
    bit exp_to;
    bit exp_perr;
    int exp_busy;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int  bc;
    int  dc;
    bit  hg;
    bit  exp_rm;

    total = 0;
    bad   = 0;
    reset = 1'b1;
    io_in_valid = 1'b0;
    io_in_ready = 1'b0;
    io_out_valid = '0;
    io_out_ready = 1'b1;
    io_out_result = '0;

    //           la   lb  dup nr leak mask skew lat0 to perr busy
    vecs[0]  = '{4,   4,   0, 0, 1'b0, 3, 0,   4, 1'b0, 1'b0, 5};
    vecs[1]  = '{3,   6,   0, 0, 1'b1, 1, 3,   3, 1'b0, 1'b0, 7};
    vecs[2]  = '{6,   3,   0, 0, 1'b1, 2, 3,   6, 1'b0, 1'b0, 7};
    vecs[3]  = '{1,   1,   0, 0, 1'b0, 3, 0,   1, 1'b0, 1'b0, 2};
    vecs[4]  = '{1,   255, 0, 0, 1'b1, 1, 254, 1, 1'b0, 1'b0, 256};
    vecs[5]  = '{5,   0,   0, 0, 1'b1, 1, 0,   5, 1'b1, 1'b0, 256};
    vecs[6]  = '{0,   0,   0, 0, 1'b1, 0, 0,   0, 1'b1, 1'b0, 256};
    vecs[7]  = '{0,   7,   0, 0, 1'b1, 2, 0,   0, 1'b1, 1'b0, 256};
    vecs[8]  = '{3,   3,   2, 0, 1'b0, 3, 0,   3, 1'b0, 1'b1, 4};
    vecs[9]  = '{3,   3,   4, 0, 1'b0, 3, 0,   3, 1'b0, 1'b1, 4};
    vecs[10] = '{2,   2,   0, 2, 1'b0, 3, 0,   3, 1'b0, 1'b0, 4};

    // Reset state.
    do_reset();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_allvalid", 32'(allValid), 0);
    chk("rst_leak", 32'(timingLeak), 0);
    chk("rst_done", 32'(timingLeakDone), 0);
    chk("rst_mask", 32'(leakMask), 0);
    chk("rst_skew", 32'(skew), 0);
    chk("rst_lat0", 32'(lat0), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_txn", 32'(txnCount), 0);
    chk("rst_perr", 32'(protoErr), 0);
    chk("rst_rmis", 32'(resultMismatch), 0);

    // Table-driven transactions, each from a fresh reset.
    for (int i = 0; i < 11; i++) begin
      do_reset();
      run_txn(vecs[i].la, vecs[i].lb, vecs[i].dup, vecs[i].nr, '0, '0, bc, dc, hg);
      chk($sformatf("v%0d_hung", i), 32'(hg), 0);
      chk($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].exp_busy));
      chk($sformatf("v%0d_done_pulses", i), 32'(dc), 1);
      chk($sformatf("v%0d_leak", i), 32'(timingLeak), 32'(vecs[i].exp_leak));
      chk($sformatf("v%0d_mask", i), 32'(leakMask), 32'(vecs[i].exp_mask));
      chk($sformatf("v%0d_skew", i), 32'(skew), 32'(vecs[i].exp_skew));
      chk($sformatf("v%0d_lat0", i), 32'(lat0), 32'(vecs[i].exp_lat0));
      chk($sformatf("v%0d_timeout", i), 32'(timeout), 32'(vecs[i].exp_to));
      chk($sformatf("v%0d_perr", i), 32'(protoErr), 32'(vecs[i].exp_perr));
      chk($sformatf("v%0d_txn", i), 32'(txnCount), 1);
      chk($sformatf("v%0d_rmis", i), 32'(resultMismatch), 0);
    end

    // Back-to-back transactions without reset: counter and per-txn values.
    do_reset();
    run_txn(2, 2, 0, 0, '0, '0, bc, dc, hg);
    chk("b2b_first_txn", 32'(txnCount), 1);
    chk("b2b_first_lat0", 32'(lat0), 2);
    run_txn(3, 5, 0, 0, '0, '0, bc, dc, hg);
    chk("b2b_hung", 32'(hg), 0);
    chk("b2b_txn", 32'(txnCount), 2);
    chk("b2b_lat0", 32'(lat0), 3);
    chk("b2b_skew", 32'(skew), 2);
    chk("b2b_mask", 32'(leakMask), 1);
    chk("b2b_leak", 32'(timingLeak), 1);

    // allValid is a registered AND; valids in IDLE start nothing.
    do_reset();
    io_out_valid = 2'b11;
    @(negedge clock);
    chk("allvalid_hi", 32'(allValid), 1);
    chk("allvalid_idle_busy", 32'(busy), 0);
    io_out_valid = 2'b01;
    @(negedge clock);
    chk("allvalid_lo", 32'(allValid), 0);
    io_out_valid = '0;

    // Reset mid-BUSY clears everything without a clock edge.
    do_reset();
    io_in_valid = 1'b1;
    io_in_ready = 1'b1;
    @(negedge clock);
    io_in_valid  = 1'b0;
    io_in_ready  = 1'b0;
    io_out_valid = 2'b01;
    @(negedge clock);
    io_out_valid = '0;
    chk("mid_pre_busy", 32'(busy), 1);
    chk("mid_pre_leak", 32'(timingLeak), 1);
    chk("mid_pre_mask", 32'(leakMask), 1);
    #1 reset = 1'b1;
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_leak", 32'(timingLeak), 0);
    chk("mid_mask", 32'(leakMask), 0);
    chk("mid_done", 32'(timingLeakDone), 0);
    #1 reset = 1'b0;
    // Accept driven right at reset release: taken on the first rising edge.
    run_txn(4, 4, 0, 0, '0, '0, bc, dc, hg);
    chk("post_busy_cycles", 32'(bc), 5);
    chk("post_lat0", 32'(lat0), 4);
    chk("post_skew", 32'(skew), 0);
    chk("post_leak", 32'(timingLeak), 0);
    chk("post_txn", 32'(txnCount), 1);

    // Result comparison: equal latency, differing results.
`ifdef SELFCOMP_RESULT_CHECK_EN
    exp_rm = 1'b1;
`else
    exp_rm = 1'b0;
`endif
    do_reset();
    run_txn(4, 4, 0, 0, 128'h5, 128'h6, bc, dc, hg);
    chk("res_rmis", 32'(resultMismatch), 32'(exp_rm));
    chk("res_leak", 32'(timingLeak), 0);
    run_txn(2, 2, 0, 0, 128'h9, 128'h9, bc, dc, hg);
    chk("res_sticky", 32'(resultMismatch), 32'(exp_rm));
    do_reset();
    run_txn(2, 2, 0, 0, 128'h7, 128'h7, bc, dc, hg);
    chk("res_equal", 32'(resultMismatch), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/selfcomp_monitor.md
SELFCOMP_MONITOR -- requirements
Module: selfcomp_monitor

Interface
REQ-001 Parameter NUM_COPIES, default 2, number of self-composed DUT copies observed (legal 2..8).
REQ-002 Parameter DATA_W, default 128, result width per copy.
REQ-003 Parameter CNT_W, default 8, width of the latency and skew counters.
REQ-004 Parameter TIMEOUT, default 255, maximum BUSY cycles allowed (must be <= 2^CNT_W-1).
REQ-005 clock  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 io_in_valid  input  1  shared DUT input valid.
REQ-008 io_in_ready  input  1  shared DUT input ready.
REQ-009 io_out_valid  input  NUM_COPIES  per-copy output valid.
REQ-010 io_out_ready  input  1  shared output ready.
REQ-011 io_out_result  input  NUM_COPIES*DATA_W  copy i at bits [i*DATA_W +: DATA_W].
REQ-012 busy  output  1  transaction outstanding.
REQ-013 allValid  output  1  registered AND of io_out_valid.
REQ-014 timingLeak  output  1  sticky divergence flag.
REQ-015 timingLeakDone  output  1  one-cycle end-of-transaction pulse.
REQ-016 leakMask  output  NUM_COPIES  copies completing in the first completion cycle.
REQ-017 skew  output  CNT_W  last minus first completion latency.
REQ-018 lat0  output  CNT_W  copy-0 latency.
REQ-019 timeout  output  1  sticky timeout flag.
REQ-020 txnCount  output  16  completed transactions, wraps at 0xFFFF->0.
REQ-021 protoErr  output  1  sticky overlapping-accept flag.
REQ-022 resultMismatch  output  1  sticky result-divergence flag.

Function
REQ-023 FSM states IDLE, BUSY, CHECK; busy is 1 in BUSY and CHECK.
REQ-024 IDLE->BUSY on io_in_valid&io_in_ready; cycle counter, done mask, leakMask cleared to 0.
REQ-025 In BUSY the cycle counter increments every cycle, saturating at 2^CNT_W-1; latency equals counter+1 at the completion edge (completion one cycle after accept = 1).
REQ-026 Copy i completes on the first BUSY cycle with io_out_valid[i]&io_out_ready and done[i]=0; later valids from that copy are ignored.
REQ-027 timingLeak sets in any BUSY cycle where at least one copy completes while another copy neither completes nor is already done.
REQ-028 leakMask captures the set of copies completing in the first completion cycle; skew = last latency - first latency.
REQ-029 BUSY->CHECK when all done bits are set, or when the counter reaches TIMEOUT with any copy still outstanding, the latter also setting timeout and timingLeak.
REQ-030 CHECK lasts exactly one cycle: timingLeakDone=1, txnCount increments, skew and lat0 updated, then ->IDLE.
REQ-031 Accept in BUSY or CHECK is ignored and sets protoErr; the accept is not counted.
REQ-032 Completion and timeout in the same cycle: completion takes priority; timeout is not set.
REQ-033 Sticky flags clear only on reset.

Reset
REQ-034 reset asserted at any time forces IDLE immediately (without waiting for a clock edge) and drives every output and internal register to 0, including mid-BUSY.
REQ-035 The first accept is recognised on the first rising edge after reset deasserts.

Configuration
REQ-036 With SELFCOMP_RESULT_CHECK_EN defined, each copy's result is captured at completion, and CHECK compares every captured result against copy 0; any difference sets resultMismatch.
REQ-037 Without SELFCOMP_RESULT_CHECK_EN, no result registers exist, io_out_result is ignored, and resultMismatch is tied to 0.

Verification
REQ-038 NUM_COPIES=2, accept, both copies valid 4 cycles later with io_out_ready=1 -> lat0=4, skew=0, timingLeak=0, single-cycle timingLeakDone, txnCount=1.
REQ-039 copy0 completes at latency 3, copy1 at latency 6 -> timingLeak=1, leakMask=2'b01, skew=3, lat0=3.
REQ-040 copy1 never valid, TIMEOUT=255 -> after 255 BUSY cycles timeout=1, timingLeak=1, timingLeakDone pulse, return to IDLE.
REQ-041 second accept while BUSY -> protoErr=1, txnCount increments only once.
REQ-042 macro defined, equal latency, results 0x5 vs 0x6 -> resultMismatch=1, timingLeak=0; macro undefined -> resultMismatch=0.
REQ-043 reset pulsed mid-BUSY -> all outputs 0 before the next clock edge; new accept afterwards behaves as REQ-038.
